// File: rtl/mdio_phy_responder.sv
// MDIO (Clause 22) PHY-side responder serving a 32 x 16 register file.
// Frame bits are taken from the synchronised MDIO line on each rising MDC. The read data is driven in the
// clk_clk cycle after the MDC rise, so it is stable at the master's next rising MDC. There is no other backpressure.
// Ports:
//   clk_clk, reset_reset_n : system clock (at least 8x MDC) and synchronous active-low reset
//   mdc, mdio_i            : management clock and resolved MDIO line from the MAC
//   mdio_o, mdio_oe        : responder drive value and output enable (active high)
//   status_in              : live value returned for register 1
//   ctrl_out               : current contents of register 0
//   wr_strobe/addr/data    : one-cycle export of each accepted write
//   frame_err              : one-cycle pulse on a bad write turnaround addressed to this PHY
module mdio_phy_responder #(
  parameter logic [4:0]  PHY_ADDR     = 5'd1,
  parameter int          PREAMBLE_LEN = 32,
  parameter logic [15:0] PHY_ID1      = 16'h0022,
  parameter logic [15:0] PHY_ID2      = 16'h1620,
  parameter logic [15:0] CTRL_RESET   = 16'h1140
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic        mdc,
  input  logic        mdio_i,
  output logic        mdio_o,
  output logic        mdio_oe,
  input  logic [15:0] status_in,
  output logic [15:0] ctrl_out,
  output logic        wr_strobe,
  output logic [4:0]  wr_addr,
  output logic [15:0] wr_data,
  output logic        frame_err
);

  localparam int PW = $clog2(PREAMBLE_LEN + 1);
  localparam logic [PW-1:0] PRE_MAX = PW'(PREAMBLE_LEN);
  localparam logic [PW-1:0] PRE_ONE = PW'(1);

  typedef enum logic [2:0] {
    S_PRE, S_START, S_OP, S_PHYAD, S_REGAD, S_TA, S_RDATA, S_WDATA
  } state_t;

  logic          r_mdc_s1, r_mdc_s2, r_mdc_s3;
  logic          r_mdio_s1, r_mdio_s2;
  logic          w_rise, w_bit;

  state_t        r_state, w_state_nxt;
  logic [PW-1:0] r_pre_cnt;
  logic [4:0]    r_bit_cnt;
  logic          r_first;     // first bit of a two-bit field (OP or TA)
  logic          r_is_read;
  logic [3:0]    r_phyad;     // leading four PHYAD bits; the fifth arrives with the decision
  logic [4:0]    r_regad;
  logic [15:0]   r_shift;

  logic [15:0]   r_ctrl;
  logic [15:0]   r_regs [0:31];

  logic          r_mdio_o, r_mdio_oe;
  logic          r_wr_strobe, r_frame_err;
  logic [4:0]    r_wr_addr;
  logic [15:0]   r_wr_data;

  logic          w_snap, w_wr_fire, w_ferr;
  logic [15:0]   w_rd_word, w_wr_word;

  // Two-flop synchronisers, plus one extra MDC stage for edge detection.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      r_mdc_s1  <= 1'b0;
      r_mdc_s2  <= 1'b0;
      r_mdc_s3  <= 1'b0;
      r_mdio_s1 <= 1'b1;
      r_mdio_s2 <= 1'b1;
    end else begin
      r_mdc_s1  <= mdc;
      r_mdc_s2  <= r_mdc_s1;
      r_mdc_s3  <= r_mdc_s2;
      r_mdio_s1 <= mdio_i;
      r_mdio_s2 <= r_mdio_s1;
    end
  end

  assign w_rise    = r_mdc_s2 & ~r_mdc_s3;
  assign w_bit     = r_mdio_s2;
  assign w_wr_word = {r_shift[14:0], w_bit};

  always_comb begin
    case (r_regad)
      5'd0:    w_rd_word = r_ctrl;
      5'd1:    w_rd_word = status_in;
      5'd2:    w_rd_word = PHY_ID1;
      5'd3:    w_rd_word = PHY_ID2;
      default: w_rd_word = r_regs[r_regad];
    endcase
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) r_state <= S_PRE;
    else                r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_snap      = 1'b0;
    w_wr_fire   = 1'b0;
    w_ferr      = 1'b0;
    if (w_rise) begin
      case (r_state)
        S_PRE:   if (!w_bit && r_pre_cnt >= PRE_MAX) w_state_nxt = S_START;
        S_START: w_state_nxt = w_bit ? S_OP : S_PRE;
        // 10 and 01 are the only legal opcodes; others drop silently.
        S_OP:    if (r_bit_cnt == 5'd1) w_state_nxt = (r_first != w_bit) ? S_PHYAD : S_PRE;
        S_PHYAD: if (r_bit_cnt == 5'd4)
                   w_state_nxt = ({r_phyad, w_bit} == PHY_ADDR) ? S_REGAD : S_PRE;
        S_REGAD: if (r_bit_cnt == 5'd4) w_state_nxt = S_TA;
        S_TA: begin
          if (r_is_read) begin
            // The read word is captured on the first turnaround bit.
            w_snap      = 1'b1;
            w_state_nxt = S_RDATA;
          end else if (r_bit_cnt == 5'd1) begin
            if (r_first && !w_bit) begin
              w_state_nxt = S_WDATA;
            end else begin
              w_ferr      = 1'b1;
              w_state_nxt = S_PRE;
            end
          end
        end
        S_RDATA: if (r_bit_cnt == 5'd16) w_state_nxt = S_PRE;
        S_WDATA: if (r_bit_cnt == 5'd15) begin
                   w_wr_fire   = 1'b1;
                   w_state_nxt = S_PRE;
                 end
        default: w_state_nxt = S_PRE;
      endcase
    end
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      r_pre_cnt   <= '0;
      r_bit_cnt   <= '0;
      r_first     <= 1'b0;
      r_is_read   <= 1'b0;
      r_phyad     <= '0;
      r_regad     <= '0;
      r_shift     <= '0;
      r_mdio_o    <= 1'b1;
      r_mdio_oe   <= 1'b0;
      r_wr_strobe <= 1'b0;
      r_frame_err <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_ctrl      <= CTRL_RESET;
      for (int i = 0; i < 32; i++) r_regs[i] <= '0;
    end else begin
      r_wr_strobe <= w_wr_fire;
      r_frame_err <= w_ferr;
      if (w_rise) begin
        // Bit counter restarts at every field boundary.
        if (w_state_nxt != r_state) r_bit_cnt <= '0;
        else                        r_bit_cnt <= r_bit_cnt + 5'd1;

        case (r_state)
          S_PRE: begin
            // A 0 bit either starts a frame or breaks the run. Either way the
            // count is cleared, so every frame needs a fresh preamble.
            if (!w_bit)                  r_pre_cnt <= '0;
            else if (r_pre_cnt < PRE_MAX) r_pre_cnt <= r_pre_cnt + PRE_ONE;
          end
          S_OP: begin
            if (r_bit_cnt == 5'd0) r_first   <= w_bit;
            else                   r_is_read <= r_first;
          end
          S_PHYAD: r_phyad <= {r_phyad[2:0], w_bit};
          S_REGAD: r_regad <= {r_regad[3:0], w_bit};
          S_TA: begin
            r_first <= w_bit;
            if (w_snap) begin
              r_shift   <= w_rd_word;
              r_mdio_oe <= 1'b1;
              r_mdio_o  <= 1'b0;
            end
          end
          S_RDATA: begin
            if (r_bit_cnt == 5'd16) begin
              r_mdio_oe <= 1'b0;
              r_mdio_o  <= 1'b1;
            end else begin
              r_mdio_o <= r_shift[15];
              r_shift  <= {r_shift[14:0], 1'b0};
            end
          end
          S_WDATA: begin
            r_shift <= w_wr_word;
            if (w_wr_fire) begin
              r_wr_addr <= r_regad;
              r_wr_data <= w_wr_word;
              // Register 0 bit 15 is a self-clearing soft reset.
              if (r_regad == 5'd0)      r_ctrl <= w_wr_word[15] ? CTRL_RESET : w_wr_word;
              else if (r_regad >= 5'd4) r_regs[r_regad] <= w_wr_word;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign mdio_o    = r_mdio_o;
  assign mdio_oe   = r_mdio_oe;
  assign ctrl_out  = r_ctrl;
  assign wr_strobe = r_wr_strobe;
  assign wr_addr   = r_wr_addr;
  assign wr_data   = r_wr_data;
  assign frame_err = r_frame_err;

endmodule

// File: tb/tb_mdio_phy_responder.sv
// Bench for mdio_phy_responder: drives MDIO frames as a master and checks them against a register-map model.
// A frame lasts one MDC bit (16 clk_clk cycles) per bit. The frame is checked after its last bit.
// The master releases the line whenever the responder drives it.
module tb_mdio_phy_responder;

  localparam logic [4:0]  PHY_ADDR   = 5'd1;
  localparam logic [15:0] CTRL_RESET = 16'h1140;
  localparam logic [15:0] PHY_ID1    = 16'h0022;
  localparam logic [15:0] PHY_ID2    = 16'h1620;

  logic        clk_clk = 1'b0;
  logic        reset_reset_n = 1'b0;
  logic        mdc = 1'b1;
  logic        m_out = 1'b1;
  logic        mdio_i;
  logic        mdio_o, mdio_oe;
  logic [15:0] status_in = 16'h0000;
  logic [15:0] ctrl_out;
  logic        wr_strobe, frame_err;
  logic [4:0]  wr_addr;
  logic [15:0] wr_data;

  mdio_phy_responder dut (
    .clk_clk      (clk_clk),
    .reset_reset_n(reset_reset_n),
    .mdc          (mdc),
    .mdio_i       (mdio_i),
    .mdio_o       (mdio_o),
    .mdio_oe      (mdio_oe),
    .status_in    (status_in),
    .ctrl_out     (ctrl_out),
    .wr_strobe    (wr_strobe),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .frame_err    (frame_err)
  );

  always #5 clk_clk = ~clk_clk;

  // Resolved line: the responder wins whenever it drives.
  assign mdio_i = mdio_oe ? mdio_o : m_out;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Register-map model
  logic [15:0] m_ctrl;
  logic [15:0] m_regs [32];
  logic        last_clean;

  task automatic model_reset();
    m_ctrl = CTRL_RESET;
    for (int i = 0; i < 32; i++) m_regs[i] = 16'h0000;
  endtask

  function automatic logic [15:0] model_read(input logic [4:0] rg);
    if (rg == 5'd0)      return m_ctrl;
    else if (rg == 5'd1) return status_in;
    else if (rg == 5'd2) return PHY_ID1;
    else if (rg == 5'd3) return PHY_ID2;
    else                 return m_regs[rg];
  endfunction

  task automatic model_write(input logic [4:0] rg, input logic [15:0] d);
    if (rg == 5'd0)       m_ctrl = d[15] ? CTRL_RESET : d;
    else if (rg >= 5'd4)  m_regs[rg] = d;
  endtask

  // Output monitor, sampled on the falling clk edge
  int          strobe_cyc, err_cyc, oe_cyc;
  logic [4:0]  cap_addr;
  logic [15:0] cap_data;

  always @(negedge clk_clk) begin
    if (wr_strobe) begin
      strobe_cyc++;
      cap_addr = wr_addr;
      cap_data = wr_data;
    end
    if (frame_err) err_cyc++;
    if (mdio_oe)   oe_cyc++;
  end

  // What the master sees on the line just before each of its rising MDC edges
  logic smp_oe [80];
  logic smp_o  [80];

  task automatic send_frame(input int pre, input logic [1:0] op, input logic [4:0] phy,
                            input logic [4:0] rg, input logic [1:0] ta, input logic [15:0] data,
                            input int abort_at);
    logic q[$];
    for (int i = 0; i < pre; i++) q.push_back(1'b1);
    q.push_back(1'b0);
    q.push_back(1'b1);
    q.push_back(op[1]);
    q.push_back(op[0]);
    for (int i = 4; i >= 0; i--) q.push_back(phy[i]);
    for (int i = 4; i >= 0; i--) q.push_back(rg[i]);
    if (op == 2'b10) begin
      for (int i = 0; i < 18; i++) q.push_back(1'b1);
    end else begin
      q.push_back(ta[1]);
      q.push_back(ta[0]);
      for (int i = 15; i >= 0; i--) q.push_back(data[i]);
    end
    for (int k = 0; k < q.size(); k++) begin
      mdc   = 1'b0;
      m_out = q[k];
      #80;
      smp_oe[k] = mdio_oe;
      smp_o[k]  = mdio_o;
      mdc = 1'b1;
      if (k == abort_at) begin
        #20;
        chk("rst_pre_oe", mdio_oe, 1'b1);
        reset_reset_n = 1'b0;
        @(posedge clk_clk);
        #1;
        chk("rst_oe", mdio_oe, 1'b0);
        repeat (3) @(posedge clk_clk);
        #1;
        reset_reset_n = 1'b1;
        model_reset();
        m_out = 1'b1;
        last_clean = 1'b1;
        return;
      end
      #80;
    end
    m_out = 1'b1;
  endtask

  task automatic run_txn(input int pre, input logic [1:0] op, input logic [4:0] phy,
                         input logic [4:0] rg, input logic [1:0] ta, input logic [15:0] data);
    logic        hdr_ok, rd, wr_ok, ta_bad;
    logic [15:0] exp_rd, got;
    int          nrise;
    hdr_ok = (pre >= 32) && (op == 2'b10 || op == 2'b01) && (phy == PHY_ADDR);
    rd     = (op == 2'b10);
    exp_rd = model_read(rg);
    strobe_cyc = 0;
    err_cyc    = 0;
    oe_cyc     = 0;
    send_frame(pre, op, phy, rg, ta, data, -1);
    #40;
    if (hdr_ok && rd) begin
      got = 16'h0000;
      for (int j = 0; j < 16; j++) got = {got[14:0], smp_o[pre + 16 + j]};
      chk("rd_data", got, exp_rd);
      chk("rd_ta_bit", {smp_oe[pre + 15], smp_o[pre + 15]}, 2'b10);
      nrise = 0;
      for (int k = 0; k < pre + 32; k++) if (smp_oe[k]) nrise++;
      chk("rd_oe_rises", nrise, 17);
    end else begin
      chk("oe_idle", oe_cyc, 0);
    end
    chk("oe_released", mdio_oe, 1'b0);
    ta_bad = (ta != 2'b10);
    wr_ok  = hdr_ok && !rd && !ta_bad;
    chk("wr_strobe_cyc", strobe_cyc, wr_ok ? 1 : 0);
    if (wr_ok) begin
      chk("wr_addr", cap_addr, rg);
      chk("wr_data", cap_data, data);
      model_write(rg, data);
    end
    chk("frame_err_cyc", err_cyc, (hdr_ok && !rd && ta_bad) ? 1 : 0);
    chk("ctrl_out", ctrl_out, m_ctrl);
    last_clean = hdr_ok && (rd || !ta_bad);
  endtask

  initial begin
    int          pre, r;
    logic [1:0]  op, ta;
    logic [4:0]  phy, rg;
    logic [15:0] d;

    model_reset();
    last_clean = 1'b1;
    repeat (5) @(posedge clk_clk);
    #3;
    chk("rst_mdio_o", mdio_o, 1'b1);
    chk("rst_mdio_oe", mdio_oe, 1'b0);
    chk("rst_wr_strobe", wr_strobe, 1'b0);
    chk("rst_wr_addr", wr_addr, 5'd0);
    chk("rst_wr_data", wr_data, 16'h0000);
    chk("rst_frame_err", frame_err, 1'b0);
    chk("rst_ctrl_out", ctrl_out, CTRL_RESET);
    reset_reset_n = 1'b1;
    #40;

    // Write and read back, then the ID and status registers
    run_txn(32, 2'b01, PHY_ADDR, 5'd4, 2'b10, 16'hA5A5);
    run_txn(32, 2'b10, PHY_ADDR, 5'd4, 2'b11, 16'h0000);
    run_txn(32, 2'b10, PHY_ADDR, 5'd2, 2'b11, 16'h0000);
    run_txn(32, 2'b10, PHY_ADDR, 5'd3, 2'b11, 16'h0000);
    status_in = 16'h796D;
    run_txn(32, 2'b10, PHY_ADDR, 5'd1, 2'b11, 16'h0000);
    // The preamble is one bit short, then a full preamble is used
    run_txn(31, 2'b01, PHY_ADDR, 5'd5, 2'b10, 16'h1234);
    run_txn(32, 2'b01, PHY_ADDR, 5'd5, 2'b10, 16'h1234);
    run_txn(32, 2'b10, PHY_ADDR, 5'd5, 2'b11, 16'h0000);
    // Foreign PHY address
    run_txn(32, 2'b10, 5'd2, 5'd4, 2'b11, 16'h0000);
    // Bad turnaround, plain control write, then a soft reset through bit 15
    run_txn(32, 2'b01, PHY_ADDR, 5'd0, 2'b11, 16'h0000);
    run_txn(32, 2'b01, PHY_ADDR, 5'd0, 2'b10, 16'h0100);
    run_txn(32, 2'b01, PHY_ADDR, 5'd0, 2'b10, 16'h8000);
    // Reset in the middle of the read data, then read again
    run_txn(32, 2'b01, PHY_ADDR, 5'd4, 2'b10, 16'hBEEF);
    send_frame(32, 2'b10, PHY_ADDR, 5'd4, 2'b11, 16'h0000, 32 + 24);
    #200;
    run_txn(33, 2'b10, PHY_ADDR, 5'd4, 2'b11, 16'h0000);
    run_txn(32, 2'b10, PHY_ADDR, 5'd2, 2'b11, 16'h0000);

    // Random traffic
    for (int n = 0; n < 36; n++) begin
      pre = (last_clean && $urandom_range(0, 5) == 0) ? 31 : 32 + int'($urandom_range(0, 3));
      r   = int'($urandom_range(0, 9));
      op  = (r < 4) ? 2'b10 : (r < 8) ? 2'b01 : (r == 8) ? 2'b00 : 2'b11;
      phy = ($urandom_range(0, 5) == 0) ? 5'($urandom_range(2, 31)) : PHY_ADDR;
      rg  = 5'($urandom_range(0, 31));
      ta  = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(0, 3)) : 2'b10;
      d   = 16'($urandom);
      status_in = 16'($urandom);
      run_txn(pre, op, phy, rg, ta, d);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mdio_phy_responder.md
Name: mdio_phy_responder

Overview:
- PHY-side MDIO management responder (IEEE 802.3 Clause 22): the target end of the MAC's MDIO master interface (mdc, mdio_out, mdio_oen, mdio_in).
- Decodes read and write frames addressed to PHY_ADDR and serves a 32 x 16 register file.
- Used as an on-chip PHY register model for red/black interface loopback and bring-up. It also exports register writes to system logic.

Parameters:
- PHY_ADDR, 5'd1, PHY address this block responds to (no broadcast support).
- PREAMBLE_LEN, 32, minimum count of consecutive 1 bits required before ST.
- PHY_ID1, 16'h0022, value returned for register 2.
- PHY_ID2, 16'h1620, value returned for register 3.
- CTRL_RESET, 16'h1140, reset value of register 0.

Ports:
- clk_clk  in  1  system clock; must be at least 8x the mdc frequency.
- reset_reset_n  in  1  synchronous, active-low reset.
- mdc  in  1  management clock from the MAC; asynchronous to clk_clk.
- mdio_i  in  1  resolved MDIO line (the master's mdio_out when its mdio_oen is active).
- mdio_o  out  1  responder drive value.
- mdio_oe  out  1  responder output enable, active high.
- status_in  in  16  live value returned when register 1 is read.
- ctrl_out  out  16  current contents of register 0.
- wr_strobe  out  1  one-cycle pulse on each accepted write.
- wr_addr  out  5  register address of the accepted write.
- wr_data  out  16  data of the accepted write.
- frame_err  out  1  one-cycle pulse on a malformed frame addressed to this PHY.

Behaviour:
- Reset values:
  - mdio_o=1, mdio_oe=0, wr_strobe=0, wr_addr=0, wr_data=0, frame_err=0.
  - ctrl_out=CTRL_RESET; registers 4..31 = 0.
  - FSM state = PREAMBLE, preamble count = 0.
- Reset asserted mid-frame: takes effect on the next clk_clk edge; the bus is released (mdio_oe=0) that cycle.
- Synchronisation and sampling:
  - mdc and mdio_i each pass through two flops; an edge register produces mdc_rise, a one-cycle pulse.
  - All frame bits are sampled from the synchronised mdio_i when mdc_rise=1.
- Output timing: mdio_o/mdio_oe change only in the clk_clk cycle after an mdc_rise, so the driven bit is stable at the master's next rising mdc.
- FSM, with one bit consumed per mdc_rise:
  - PREAMBLE: bit 1 increments the count, saturating at PREAMBLE_LEN. Bit 0 goes to START if count >= PREAMBLE_LEN, otherwise clears the count.
  - START: expects 1 (ST=01). Bit 0 goes to PREAMBLE with count 0.
  - OP: 2 bits. 10 = read, 01 = write. 00/11 go to PREAMBLE and pulse frame_err only if the address later... (no: address unknown, so no frame_err).
  - PHYAD: 5 bits, MSB first. After the 5th bit, a mismatch with PHY_ADDR goes to PREAMBLE silently.
  - REGAD: 5 bits, MSB first.
  - TA, read: at the rise of TA bit 1, snapshot the read word. After that rise, drive mdio_oe=1, mdio_o=0.
  - TA, write: sample 2 bits. Anything other than 10 pulses frame_err and goes to PREAMBLE with no write.
  - RDATA: after each of the next 16 rises, drive data MSB first. After the rise that sampled data bit 0, set mdio_oe=0 and go to PREAMBLE.
  - WDATA: shift 16 bits. In the cycle after the rise sampling bit 0, perform the register update and pulse wr_strobe/wr_addr/wr_data for exactly 1 cycle, then go to PREAMBLE.
- Preamble after each frame: every frame ends with count=0, so every frame needs a new full preamble (no preamble suppression).
- Register map:
  - Reg 0: RW; bit 15 self-clears and, when written 1, restores CTRL_RESET.
  - Reg 1: reads status_in, sampled at the TA snapshot.
  - Regs 2/3: read PHY_ID1/PHY_ID2.
  - Regs 4..31: RW.
  - Writes to regs 1..3 are discarded but still pulse wr_strobe.
- Master collision: mdio_i is ignored while the responder drives the line.

Test Plan:
- 32x1 preamble, write PHYAD=1 REGAD=4 data 16'hA5A5, TA=10 -> wr_strobe one cycle, wr_addr=4, wr_data=A5A5. A following read of reg 4 -> mdio_oe high from TA bit 2, bits 0 then A5A5 MSB-first, mdio_oe low after the 18th driven rise.
- Read reg 2 and reg 3 -> 16'h0022 and 16'h1620. Read reg 1 with status_in=16'h796D -> 796D.
- Read with PHYAD=2 -> mdio_oe stays 0 for the whole frame, no wr_strobe, no frame_err.
- Preamble of 31 ones, then a valid write -> ignored. A subsequent frame with 32 ones -> accepted.
- Write reg 0 with TA=11 -> frame_err pulse, ctrl_out remains 16'h1140. Write reg 0 data 16'h8000 -> ctrl_out=16'h1140 (bit 15 self-cleared).
- Assert reset_reset_n=0 during RDATA bit 7 -> mdio_oe=0 the next cycle. The next valid read returns the correct data.
